// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared FSM encoding and port indices for the two-port RAM arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// rtl/ram_arb_grant.sv - combinational one-hot grant from the two request valids and the last-grant bit
module ram_arb_grant
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = port_onehot(PORT_IFETCH);
            2'b10:   grant = port_onehot(PORT_DATA);
            2'b11:   grant = port_onehot(~last_grant);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master request sequencer in front of a single-port RAM; RAM_ARB_RR_EN selects round-robin arbitration
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  i_req0_valid,
    input  logic                  i_req0_write,
    input  logic [ADDR_WIDTH-1:0] i_req0_address,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic                  o_req0_ready,
    output logic                  o_rsp0_valid,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,

    input  logic                  i_req1_valid,
    input  logic                  i_req1_write,
    input  logic [ADDR_WIDTH-1:0] i_req1_address,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_rsp1_valid,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,

    output logic                  o_ram_read,
    output logic                  o_ram_write,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic                  i_ram_done,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    state_t                  state;
    logic                    owner;
    logic                    cur_write;
    logic [1:0]              req_valid;
    logic [1:0]              grant;
    logic                    last_grant;
    logic                    grant_port;
    logic                    handshake;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_address;
    logic [DATA_WIDTH-1:0]   sel_data;

    assign req_valid = {i_req1_valid, i_req0_valid};

`ifdef RAM_ARB_RR_EN
    // Reset value makes port 0 the winner of the first contended grant.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant <= PORT_DATA;
        end else if (handshake) begin
            last_grant <= grant_port;
        end
    end
`else
    assign last_grant = PORT_DATA;
`endif

    ram_arb_grant u_grant (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign o_req0_ready = (state == IDLE) & grant[PORT_IFETCH];
    assign o_req1_ready = (state == IDLE) & grant[PORT_DATA];
    assign handshake    = o_req0_ready | o_req1_ready;
    assign grant_port   = grant[PORT_DATA];

    assign sel_write   = grant_port ? i_req1_write   : i_req0_write;
    assign sel_address = grant_port ? i_req1_address : i_req0_address;
    assign sel_data    = grant_port ? i_req1_data    : i_req0_data;

    // Strobes are registered on the handshake edge so they are high exactly while state is ISSUE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            owner         <= PORT_IFETCH;
            cur_write     <= 1'b0;
            o_ram_read    <= 1'b0;
            o_ram_write   <= 1'b0;
            o_ram_address <= '0;
            o_ram_data    <= '0;
            o_rsp0_valid  <= 1'b0;
            o_rsp1_valid  <= 1'b0;
            o_rsp0_data   <= '0;
            o_rsp1_data   <= '0;
        end else begin
            o_ram_read   <= 1'b0;
            o_ram_write  <= 1'b0;
            o_rsp0_valid <= 1'b0;
            o_rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        owner         <= grant_port;
                        cur_write     <= sel_write;
                        o_ram_address <= sel_address;
                        o_ram_data    <= sel_data;
                        o_ram_read    <= ~sel_write;
                        o_ram_write   <= sel_write;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_ram_done) begin
                        state <= IDLE;
                        if (owner == PORT_DATA) begin
                            o_rsp1_valid <= 1'b1;
                            if (!cur_write) begin
                                o_rsp1_data <= i_ram_data;
                            end
                        end else begin
                            o_rsp0_valid <= 1'b1;
                            if (!cur_write) begin
                                o_rsp0_data <= i_ram_data;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
